// File: rtl/y86_pipe_stage_reg.sv
// Generic Y86 pipeline boundary register: load / stall / bubble with a valid bit,
// saturating stall/bubble event counters, a consecutive-stall watchdog and a sticky conflict flag.
module y86_pipe_stage_reg #(
    parameter int         DATA_W    = 64,
    parameter int         NUM_VALS  = 3,
    parameter int         NUM_REGS  = 4,
    parameter logic [3:0] NOP_ICODE = 4'h1,
    parameter logic [3:0] RNONE     = 4'hF,
    parameter logic [1:0] STAT_AOK  = 2'd0,
    parameter int         CNT_W     = 16,
    parameter int         MAX_STALL = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         bubble,
    input  logic [1:0]                   in_stat,
    input  logic [3:0]                   in_icode,
    input  logic [3:0]                   in_ifun,
    input  logic [NUM_VALS*DATA_W-1:0]   in_vals,
    input  logic [NUM_REGS*4-1:0]        in_regs,
    output logic [1:0]                   out_stat,
    output logic [3:0]                   out_icode,
    output logic [3:0]                   out_ifun,
    output logic [NUM_VALS*DATA_W-1:0]   out_vals,
    output logic [NUM_REGS*4-1:0]        out_regs,
    output logic                         out_valid,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             bubble_cnt,
    output logic                         stall_timeout,
    output logic                         conflict
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_STALL);

    typedef struct packed {
        logic [1:0]                         stat;
        logic [3:0]                         icode;
        logic [3:0]                         ifun;
        logic [NUM_VALS-1:0][DATA_W-1:0]    vals;
        logic [NUM_REGS-1:0][3:0]           regs;
    } stage_t;

    stage_t           nop_c, in_c;
    stage_t           st_q, st_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;
    logic             conflict_q, conflict_d;

    // Bubble and reset contents: a NOP with no register destinations.
    always_comb begin
        nop_c       = '0;
        nop_c.stat  = STAT_AOK;
        nop_c.icode = NOP_ICODE;
        for (int k = 0; k < NUM_REGS; k++) begin
            nop_c.regs[k] = RNONE;
        end
    end

    always_comb begin
        in_c       = '0;
        in_c.stat  = in_stat;
        in_c.icode = in_icode;
        in_c.ifun  = in_ifun;
        in_c.vals  = in_vals;
        in_c.regs  = in_regs;
    end

    always_comb begin
        st_d         = st_q;
        vld_d        = vld_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        run_d        = run_q;
        conflict_d   = conflict_q;
        if (bubble) begin
            // Bubble wins over a simultaneous stall; the stall is not counted.
            st_d  = nop_c;
            vld_d = 1'b0;
            run_d = '0;
            if (bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + 1'b1;
            if (stall)                   conflict_d   = 1'b1;
        end else if (stall) begin
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
            if (run_q != RUN_MAX)       run_d       = run_q + 1'b1;
        end else begin
            st_d  = in_c;
            vld_d = 1'b1;
            run_d = '0;
        end
        timeout_d = (run_d == RUN_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= nop_c;
            vld_q        <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            run_q        <= '0;
            timeout_q    <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            st_q         <= st_d;
            vld_q        <= vld_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            run_q        <= run_d;
            timeout_q    <= timeout_d;
            conflict_q   <= conflict_d;
        end
    end

    assign out_stat      = st_q.stat;
    assign out_icode     = st_q.icode;
    assign out_ifun      = st_q.ifun;
    assign out_vals      = st_q.vals;
    assign out_regs      = st_q.regs;
    assign out_valid     = vld_q;
    assign stall_cnt     = stall_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign stall_timeout = timeout_q;
    assign conflict      = conflict_q;

endmodule

// File: tb/tb_y86_pipe_stage_reg.sv
// Directed bench for y86_pipe_stage_reg: a default instance plus a CNT_W=4 instance for saturation.
module tb_y86_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst, stall, bubble;
    logic [1:0]   in_stat;
    logic [3:0]   in_icode, in_ifun;
    logic [191:0] in_vals;
    logic [15:0]  in_regs;

    logic [1:0]   a_stat, b_stat;
    logic [3:0]   a_icode, a_ifun, b_icode, b_ifun;
    logic [191:0] a_vals, b_vals;
    logic [15:0]  a_regs, b_regs;
    logic         a_valid, a_to, a_conf, b_valid, b_to, b_conf;
    logic [15:0]  a_scnt, a_bcnt;
    logic [3:0]   b_scnt, b_bcnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    y86_pipe_stage_reg u_a (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
        .in_vals(in_vals), .in_regs(in_regs),
        .out_stat(a_stat), .out_icode(a_icode), .out_ifun(a_ifun),
        .out_vals(a_vals), .out_regs(a_regs), .out_valid(a_valid),
        .stall_cnt(a_scnt), .bubble_cnt(a_bcnt),
        .stall_timeout(a_to), .conflict(a_conf)
    );

    y86_pipe_stage_reg #(.CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
        .in_vals(in_vals), .in_regs(in_regs),
        .out_stat(b_stat), .out_icode(b_icode), .out_ifun(b_ifun),
        .out_vals(b_vals), .out_regs(b_regs), .out_valid(b_valid),
        .stall_cnt(b_scnt), .bubble_cnt(b_bcnt),
        .stall_timeout(b_to), .conflict(b_conf)
    );

    task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_nop(input string tag);
        chk({tag, "_icode"}, 192'(a_icode), 192'h1);
        chk({tag, "_ifun"},  192'(a_ifun),  192'h0);
        chk({tag, "_stat"},  192'(a_stat),  192'h0);
        chk({tag, "_regs"},  192'(a_regs),  192'hFFFF);
        chk({tag, "_vals"},  a_vals,        192'h0);
        chk({tag, "_valid"}, 192'(a_valid), 192'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        in_stat = 2'd0; in_icode = 4'h0; in_ifun = 4'h0; in_vals = '0; in_regs = '0;
        #1;

        // Reset state
        tick(2);
        chk_nop("rst");
        chk("rst_scnt", 192'(a_scnt), 192'h0);
        chk("rst_bcnt", 192'(a_bcnt), 192'h0);
        chk("rst_to",   192'(a_to),   192'h0);
        chk("rst_conf", 192'(a_conf), 192'h0);

        // Load: field0=5, field1=7, field2=0; regs field0..3 = 3,4,F,0
        rst = 1'b0;
        in_stat = 2'd1; in_icode = 4'h6; in_ifun = 4'h2;
        in_vals = {64'd0, 64'd7, 64'd5};
        in_regs = 16'h0F43;
        tick(1);
        chk("ld_icode", 192'(a_icode), 192'h6);
        chk("ld_ifun",  192'(a_ifun),  192'h2);
        chk("ld_stat",  192'(a_stat),  192'h1);
        chk("ld_vals",  a_vals, {64'd0, 64'd7, 64'd5});
        chk("ld_regs",  192'(a_regs),  192'h0F43);
        chk("ld_valid", 192'(a_valid), 192'h1);

        // Stall hold
        in_icode = 4'h3;
        tick(1);
        stall = 1'b1; in_icode = 4'h9;
        tick(3);
        chk("st_icode", 192'(a_icode), 192'h3);
        chk("st_scnt",  192'(a_scnt),  192'd3);
        chk("st_valid", 192'(a_valid), 192'h1);
        stall = 1'b0;
        tick(1);
        chk("st_rel_icode", 192'(a_icode), 192'h9);
        chk("st_rel_scnt",  192'(a_scnt),  192'd3);

        // Bubble
        bubble = 1'b1;
        tick(1);
        bubble = 1'b0;
        chk_nop("bub");
        chk("bub_bcnt", 192'(a_bcnt), 192'd1);
        chk("bub_conf", 192'(a_conf), 192'h0);

        // Conflict: bubble wins, stall not counted, flag sticky until rst
        tick(1);
        chk("pre_conf_valid", 192'(a_valid), 192'h1);
        stall = 1'b1; bubble = 1'b1;
        tick(1);
        stall = 1'b0; bubble = 1'b0;
        chk_nop("conf");
        chk("conf_flag", 192'(a_conf), 192'h1);
        chk("conf_scnt", 192'(a_scnt), 192'd3);
        chk("conf_bcnt", 192'(a_bcnt), 192'd2);
        tick(10);
        chk("conf_hold",  192'(a_conf),  192'h1);
        chk("conf_valid", 192'(a_valid), 192'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("conf_clr", 192'(a_conf), 192'h0);

        // Watchdog at MAX_STALL=8
        tick(1);
        stall = 1'b1;
        tick(7);
        chk("wd7_to",   192'(a_to),   192'h0);
        chk("wd7_scnt", 192'(a_scnt), 192'd7);
        tick(1);
        chk("wd8_to",   192'(a_to),   192'h1);
        chk("wd8_b_to", 192'(b_to),   192'h1);
        tick(4);
        chk("wd12_to",   192'(a_to),   192'h1);
        chk("wd12_scnt", 192'(a_scnt), 192'd12);
        stall = 1'b0;
        tick(1);
        chk("wd_ld_to",  192'(a_to),   192'h0);

        // Saturation with CNT_W=4
        rst = 1'b1;
        tick(1);
        rst = 1'b0; bubble = 1'b1;
        tick(20);
        bubble = 1'b0;
        chk("sat_b_bcnt", 192'(b_bcnt), 192'd15);
        chk("sat_a_bcnt", 192'(a_bcnt), 192'd20);
        stall = 1'b1;
        tick(20);
        chk("sat_b_scnt", 192'(b_scnt), 192'd15);
        chk("sat_a_scnt", 192'(a_scnt), 192'd20);
        chk("sat_b_to",   192'(b_to),   192'h1);

        // rst mid-stall overrides everything
        rst = 1'b1;
        tick(1);
        chk("rst_mid_scnt",  192'(b_scnt),  192'h0);
        chk("rst_mid_bcnt",  192'(b_bcnt),  192'h0);
        chk("rst_mid_to",    192'(b_to),    192'h0);
        chk("rst_mid_valid", 192'(b_valid), 192'h0);
        chk("rst_mid_ascnt", 192'(a_scnt),  192'h0);
        chk("rst_mid_abcnt", 192'(a_bcnt),  192'h0);
        rst = 1'b0; stall = 1'b0;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
